complex_divider: RTL

Iterative fixed-point complex divider q = a / b over the `complex` package packed types. It is the inverse companion of `complex_multiplier` and sits in the same datapaths, for example equalizer and channel-correction chains that undo a complex gain. It computes a·conj(b) and |b|², then runs two parallel radix-2 restoring divisions, one quotient bit per cycle. A valid/ready handshake on both sides decouples it from the surrounding pipeline.

---
 rtl/complex_divider.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/complex_divider.sv
// complex_divider: iterative restoring divider q = a / b on packed {re, im}.
// Define COMPLEX_DIVIDER_SAT_EN to clamp the quotient; otherwise it wraps.
module complex_divider #(
  parameter int A_WIDTH   = 10,
  parameter int B_WIDTH   = 15,
  parameter int FRAC_BITS = 8,
  parameter int Q_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*A_WIDTH-1:0]   a_i,
  input  logic [2*B_WIDTH-1:0]   b_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [2*Q_WIDTH-1:0]   q_o,
  output logic                   dz_o,
  output logic                   ovf_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i
);

  localparam int PW        = A_WIDTH + B_WIDTH;
  localparam int NUM_WIDTH = PW + FRAC_BITS;
  localparam int DEN_WIDTH = 2 * B_WIDTH;
  localparam int ITER      = NUM_WIDTH;
  localparam int CW        = $clog2(ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIV,
    S_FIN,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [A_WIDTH-1:0] r_a_re;
  logic signed [A_WIDTH-1:0] r_a_im;
  logic signed [B_WIDTH-1:0] r_b_re;
  logic signed [B_WIDTH-1:0] r_b_im;

  logic [NUM_WIDTH-1:0] r_num_re;
  logic [NUM_WIDTH-1:0] r_num_im;
  logic [DEN_WIDTH-1:0] r_rem_re;
  logic [DEN_WIDTH-1:0] r_rem_im;
  logic [DEN_WIDTH-1:0] r_den;
  logic                 r_neg_re;
  logic                 r_neg_im;
  logic [CW-1:0]        r_cnt;

  logic [Q_WIDTH-1:0] r_q_re;
  logic [Q_WIDTH-1:0] r_q_im;
  logic               r_dz;
  logic               r_ovf;
  logic               r_valid;

  logic w_load;
  logic w_prep;
  logic w_step;
  logic w_fin;
  logic w_rel;
  logic w_rdy;

  function automatic logic signed [PW-1:0] smul(
    logic signed [A_WIDTH-1:0] x,
    logic signed [B_WIDTH-1:0] y
  );
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ye;
    xe = PW'(x);
    ye = PW'(y);
    return xe * ye;
  endfunction

`ifdef COMPLEX_DIVIDER_SAT_EN
  localparam logic [NUM_WIDTH-1:0] QLIM =
    NUM_WIDTH'(1) << (Q_WIDTH - 1);
`endif

  // Returns {ovf, q}; a zero magnitude always yields +0.
  function automatic logic [Q_WIDTH:0] finish(
    logic [NUM_WIDTH-1:0] m,
    logic                 neg
  );
    logic [Q_WIDTH-1:0] q;
    logic               o;
    q = neg ? -m[Q_WIDTH-1:0] : m[Q_WIDTH-1:0];
    o = 1'b0;
`ifdef COMPLEX_DIVIDER_SAT_EN
    if (!neg && m >= QLIM) begin
      q = {1'b0, {(Q_WIDTH-1){1'b1}}};
      o = 1'b1;
    end else if (neg && m > QLIM) begin
      q = {1'b1, {(Q_WIDTH-1){1'b0}}};
      o = 1'b1;
    end
`endif
    return {o, q};
  endfunction

  logic signed [PW-1:0] w_ar_br;
  logic signed [PW-1:0] w_ai_bi;
  logic signed [PW-1:0] w_ai_br;
  logic signed [PW-1:0] w_ar_bi;
  logic signed [PW:0]   w_n_re;
  logic signed [PW:0]   w_n_im;
  logic [PW-1:0]        w_abs_re;
  logic [PW-1:0]        w_abs_im;

  assign w_ar_br = smul(r_a_re, r_b_re);
  assign w_ai_bi = smul(r_a_im, r_b_im);
  assign w_ai_br = smul(r_a_im, r_b_re);
  assign w_ar_bi = smul(r_a_re, r_b_im);

  assign w_n_re = (PW+1)'(w_ar_br) + (PW+1)'(w_ai_bi);
  assign w_n_im = (PW+1)'(w_ai_br) - (PW+1)'(w_ar_bi);

  assign w_abs_re = w_n_re[PW] ? PW'(-w_n_re) : w_n_re[PW-1:0];
  assign w_abs_im = w_n_im[PW] ? PW'(-w_n_im) : w_n_im[PW-1:0];

  logic signed [DEN_WIDTH-1:0] w_bre_e;
  logic signed [DEN_WIDTH-1:0] w_bim_e;
  logic [DEN_WIDTH-1:0]        w_d;

  assign w_bre_e = DEN_WIDTH'(r_b_re);
  assign w_bim_e = DEN_WIDTH'(r_b_im);
  assign w_d     = w_bre_e * w_bre_e + w_bim_e * w_bim_e;

  // One restoring step: bring in the next numerator bit, trial-subtract d.
  logic [DEN_WIDTH:0]   w_tr_re;
  logic [DEN_WIDTH:0]   w_tr_im;
  logic                 w_qb_re;
  logic                 w_qb_im;
  logic [DEN_WIDTH-1:0] w_rem_re;
  logic [DEN_WIDTH-1:0] w_rem_im;

  assign w_tr_re = {r_rem_re, r_num_re[NUM_WIDTH-1]};
  assign w_tr_im = {r_rem_im, r_num_im[NUM_WIDTH-1]};
  assign w_qb_re = (w_tr_re >= {1'b0, r_den});
  assign w_qb_im = (w_tr_im >= {1'b0, r_den});

  assign w_rem_re = w_qb_re ? DEN_WIDTH'(w_tr_re - {1'b0, r_den})
                            : w_tr_re[DEN_WIDTH-1:0];
  assign w_rem_im = w_qb_im ? DEN_WIDTH'(w_tr_im - {1'b0, r_den})
                            : w_tr_im[DEN_WIDTH-1:0];

  logic [Q_WIDTH:0] w_f_re;
  logic [Q_WIDTH:0] w_f_im;

  assign w_f_re = finish(r_num_re, r_neg_re);
  assign w_f_im = finish(r_num_im, r_neg_im);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid_i) w_next = S_PREP;
      S_PREP: w_next = S_DIV;
      S_DIV:  if (r_cnt == '0) w_next = S_FIN;
      S_FIN:  w_next = S_HOLD;
      S_HOLD: if (out_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_prep = 1'b0;
    w_step = 1'b0;
    w_fin  = 1'b0;
    w_rel  = 1'b0;
    w_rdy  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_rdy  = 1'b1;
        w_load = in_valid_i;
      end
      S_PREP: w_prep = 1'b1;
      S_DIV:  w_step = 1'b1;
      S_FIN:  w_fin  = 1'b1;
      S_HOLD: w_rel  = out_ready_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_re   <= '0;
      r_a_im   <= '0;
      r_b_re   <= '0;
      r_b_im   <= '0;
      r_num_re <= '0;
      r_num_im <= '0;
      r_rem_re <= '0;
      r_rem_im <= '0;
      r_den    <= '0;
      r_neg_re <= 1'b0;
      r_neg_im <= 1'b0;
      r_cnt    <= '0;
      r_q_re   <= '0;
      r_q_im   <= '0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_load) begin
        r_a_re <= a_i[2*A_WIDTH-1:A_WIDTH];
        r_a_im <= a_i[A_WIDTH-1:0];
        r_b_re <= b_i[2*B_WIDTH-1:B_WIDTH];
        r_b_im <= b_i[B_WIDTH-1:0];
      end
      if (w_prep) begin
        r_num_re <= {w_abs_re, {FRAC_BITS{1'b0}}};
        r_num_im <= {w_abs_im, {FRAC_BITS{1'b0}}};
        r_den    <= w_d;
        r_neg_re <= w_n_re[PW];
        r_neg_im <= w_n_im[PW];
        r_rem_re <= '0;
        r_rem_im <= '0;
        r_cnt    <= CW'(ITER - 1);
      end
      // Numerator register doubles as quotient: bits shift out, q bits in.
      if (w_step) begin
        r_num_re <= {r_num_re[NUM_WIDTH-2:0], w_qb_re};
        r_num_im <= {r_num_im[NUM_WIDTH-2:0], w_qb_im};
        r_rem_re <= w_rem_re;
        r_rem_im <= w_rem_im;
        r_cnt    <= r_cnt - CW'(1);
      end
      if (w_fin) begin
        r_valid <= 1'b1;
        if (r_den == '0) begin
          r_q_re <= '0;
          r_q_im <= '0;
          r_dz   <= 1'b1;
          r_ovf  <= 1'b0;
        end else begin
          r_q_re <= w_f_re[Q_WIDTH-1:0];
          r_q_im <= w_f_im[Q_WIDTH-1:0];
          r_dz   <= 1'b0;
          r_ovf  <= w_f_re[Q_WIDTH] | w_f_im[Q_WIDTH];
        end
      end
      if (w_rel) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign in_ready_o  = w_rdy;
  assign q_o         = {r_q_re, r_q_im};
  assign dz_o        = r_dz;
  assign ovf_o       = r_ovf;
  assign out_valid_o = r_valid;

endmodule
